// File: rtl/neuron_state_detector_pkg.sv
// Shared class encodings and helpers for the neuron state detector.
// The ON/NEAR/OFF codes are fixed so downstream reward logic can decode them.
package neuron_state_detector_pkg;

  typedef enum logic [1:0] {
    CLS_OFF  = 2'd0,
    CLS_NEAR = 2'd1,
    CLS_ON   = 2'd2
  } nsd_class_e;

  // Legacy on/off meaning: anything other than OFF counts as active
  function automatic logic cls_is_active(input nsd_class_e cls);
    logic result;
    case (cls)
      CLS_ON:   result = 1'b1;
      CLS_NEAR: result = 1'b1;
      CLS_OFF:  result = 1'b0;
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic cls_is_near(input nsd_class_e cls);
    logic result;
    case (cls)
      CLS_NEAR: result = 1'b1;
      CLS_ON:   result = 1'b0;
      CLS_OFF:  result = 1'b0;
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/neuron_state_detector_if.sv
// Sample/result bundle between the membrane source and the state detector.
interface neuron_state_detector_if #(
  parameter int W    = 16,
  parameter int N_CH = 8
);
  localparam int CNT_W = $clog2(N_CH + 1);

  logic                  in_valid;
  logic [N_CH*W-1:0]     v_mem;
  logic [W-1:0]          v_th;
  logic [W-1:0]          eta;
  logic                  out_valid;
  logic [N_CH-1:0]       active;
  logic [N_CH-1:0]       near;
  logic [N_CH-1:0]       change_pulse;
  logic [CNT_W-1:0]      active_count;

  modport master (
    output in_valid, v_mem, v_th, eta,
    input  out_valid, active, near, change_pulse, active_count
  );

  modport slave (
    input  in_valid, v_mem, v_th, eta,
    output out_valid, active, near, change_pulse, active_count
  );
endinterface

// File: rtl/neuron_state_detector_nsd_channel.sv
// One neuron channel: raw OFF/NEAR/ON classifier followed by a dwell-debounced
// commit FSM with registered active/near/change outputs.
module nsd_channel
  import neuron_state_detector_pkg::*;
#(
  parameter int W     = 16,
  parameter int DWELL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] v_mem,
  input  logic [W-1:0] v_th,
  input  logic [W-1:0] eta,
  output logic         active,
  output logic         near,
  output logic         change_pulse
);
  localparam int DW = W + 2;
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic signed [DW-1:0] d_s;
  logic signed [DW-1:0] eta_s;
  logic signed [DW-1:0] neg_eta_s;
  nsd_class_e           raw_s;
  logic [CW-1:0]        next_cnt_s;

  nsd_class_e           committed_r;
  nsd_class_e           cand_r;
  logic [CW-1:0]        cnt_r;
  logic                 active_r;
  logic                 near_r;
  logic                 pulse_r;

  // Two guard bits keep v_mem - v_th and -eta exact over the full input range
  always_comb begin
    d_s       = signed'({{2{v_mem[W-1]}}, v_mem}) - signed'({{2{v_th[W-1]}}, v_th});
    eta_s     = signed'({2'b00, eta});
    neg_eta_s = -eta_s;
    if (d_s > eta_s) begin
      raw_s = CLS_ON;
    end else if ((d_s < eta_s) && (d_s > neg_eta_s)) begin
      raw_s = CLS_NEAR;
    end else begin
      raw_s = CLS_OFF;
    end
  end

  // Dwell count this sample would reach if it differs from the committed class
  always_comb begin
    if (raw_s == cand_r) begin
      next_cnt_s = cnt_r + ONE_C;
    end else begin
      next_cnt_s = ONE_C;
    end
  end

  // Commit FSM; invalid cycles freeze state and only drop the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      committed_r <= CLS_OFF;
      cand_r      <= CLS_OFF;
      cnt_r       <= '0;
      active_r    <= 1'b0;
      near_r      <= 1'b0;
      pulse_r     <= 1'b0;
    end else if (in_valid) begin
      if (raw_s == committed_r) begin
        cnt_r   <= '0;
        pulse_r <= 1'b0;
      end else if (next_cnt_s == DWELL_C) begin
        committed_r <= raw_s;
        cand_r      <= raw_s;
        cnt_r       <= '0;
        active_r    <= cls_is_active(raw_s);
        near_r      <= cls_is_near(raw_s);
        pulse_r     <= 1'b1;
      end else begin
        cand_r  <= raw_s;
        cnt_r   <= next_cnt_s;
        pulse_r <= 1'b0;
      end
    end else begin
      pulse_r <= 1'b0;
    end
  end

  assign active       = active_r;
  assign near         = near_r;
  assign change_pulse = pulse_r;

endmodule

// File: rtl/neuron_state_detector.sv
// Multi-channel neuron state detector: N_CH debounced OFF/NEAR/ON channels,
// a registered valid and a popcount of committed active channels.
module neuron_state_detector
  import neuron_state_detector_pkg::*;
#(
  parameter int W     = 16,
  parameter int N_CH  = 8,
  parameter int DWELL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_state_detector_if.slave   bus
);
  localparam int CNT_W = $clog2(N_CH + 1);

  logic              out_valid_r;
  logic [N_CH-1:0]   active_s;
  logic [N_CH-1:0]   near_s;
  logic [N_CH-1:0]   pulse_s;
  logic [CNT_W-1:0]  count_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    nsd_channel #(
      .W     (W),
      .DWELL (DWELL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (bus.in_valid),
      .v_mem        (bus.v_mem[i*W +: W]),
      .v_th         (bus.v_th),
      .eta          (bus.eta),
      .active       (active_s[i]),
      .near         (near_s[i]),
      .change_pulse (pulse_s[i])
    );
  end

  // Output valid tracks the input sample one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.in_valid;
    end
  end

  // Popcount of the already-registered active vector
  always_comb begin
    count_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      count_s = count_s + CNT_W'(active_s[i]);
    end
  end

  assign bus.out_valid    = out_valid_r;
  assign bus.active       = active_s;
  assign bus.near         = near_s;
  assign bus.change_pulse = pulse_s;
  assign bus.active_count = count_s;

endmodule
